// File: rtl/afe_tdm_mux.sv
// Eight-slot TDM serialiser from the per-headstage SPI masters to the 10-bit PC bus.
// Optional test-pattern mode is compiled in with AFE_TDM_TESTPAT_EN.
module afe_tdm_mux #(
  parameter int unsigned   N_MOD     = 8,
  parameter int unsigned   DW        = 10,
  parameter int unsigned   SLOT_HALF = 5,
  parameter logic [5:0]    SYNC_CH   = 6'd2,
  parameter logic [DW-1:0] IDLE_WORD = DW'(512)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic [5:0]          in_ch,
  input  logic [N_MOD*DW-1:0] in_a,
  input  logic [N_MOD*DW-1:0] in_b,
`ifdef AFE_TDM_TESTPAT_EN
  input  logic                tp_en,
`endif
  input  logic                ovr_clr,
  output logic [DW-1:0]       out_a,
  output logic [DW-1:0]       out_b,
  output logic                out_clk,
  output logic [2:0]          out_slot,
  output logic                out_sync,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned CYC_N = 2 * SLOT_HALF;
  localparam int unsigned CYC_W = $clog2(CYC_N);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t              state, nxt_state;
  logic [2:0]          slot, nxt_slot;
  logic [CYC_W-1:0]    cyc, nxt_cyc;

  logic [N_MOD*DW-1:0] sh_a, sh_b, pl_a, pl_b;
  logic [5:0]          sh_ch, pl_ch;
  logic                pending, nxt_pending, nxt_overrun;

  logic                last_cyc, last_slot, load;
  logic [N_MOD*DW-1:0] src_a, src_b;
  logic [5:0]          src_ch;
  logic [DW-1:0]       a_arr [N_MOD];
  logic [DW-1:0]       b_arr [N_MOD];

  logic [DW-1:0]       nxt_out_a, nxt_out_b;
  logic                nxt_out_clk, nxt_out_sync, nxt_busy;

  // Sequencer next state, bank hand-off and next registered outputs
  always_comb begin
    nxt_state    = state;
    nxt_slot     = slot;
    nxt_cyc      = cyc;
    nxt_out_a    = IDLE_WORD;
    nxt_out_b    = IDLE_WORD;
    nxt_out_clk  = 1'b0;
    nxt_out_sync = 1'b0;
    nxt_busy     = 1'b0;

    last_cyc  = (cyc == CYC_W'(CYC_N - 1));
    last_slot = (slot == 3'(N_MOD - 1));
    load      = pending && ((state == S_IDLE) || (last_cyc && last_slot));

    case (state)
      S_IDLE: begin
        if (load) begin
          nxt_state = S_PLAY;
          nxt_slot  = 3'd0;
          nxt_cyc   = '0;
        end
      end
      S_PLAY: begin
        if (last_cyc) begin
          nxt_cyc = '0;
          if (last_slot) begin
            nxt_slot  = 3'd0;
            nxt_state = load ? S_PLAY : S_IDLE;
          end else begin
            nxt_slot = slot + 3'd1;
          end
        end else begin
          nxt_cyc = cyc + CYC_W'(1);
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // A loading edge plays straight from the shadow bank
    src_a  = load ? sh_a  : pl_a;
    src_b  = load ? sh_b  : pl_b;
    src_ch = load ? sh_ch : pl_ch;
    for (int k = 0; k < int'(N_MOD); k++) begin
      a_arr[k] = src_a[k*DW +: DW];
      b_arr[k] = src_b[k*DW +: DW];
    end

    if (nxt_state == S_PLAY) begin
      nxt_out_a    = a_arr[nxt_slot];
      nxt_out_b    = b_arr[nxt_slot];
      nxt_out_clk  = (nxt_cyc < CYC_W'(SLOT_HALF));
      nxt_out_sync = (nxt_slot == 3'd0) && (src_ch == SYNC_CH);
      nxt_busy     = 1'b1;
`ifdef AFE_TDM_TESTPAT_EN
      if (tp_en) begin
        nxt_out_a = DW'({1'b0, nxt_slot, src_ch});
        nxt_out_b = DW'({1'b1, nxt_slot, src_ch});
      end
`endif
    end

    // Newest frame always wins; set beats clear on overrun
    nxt_pending = in_valid ? 1'b1 : (load ? 1'b0 : pending);
    if (in_valid && pending && !load)
      nxt_overrun = 1'b1;
    else if (ovr_clr)
      nxt_overrun = 1'b0;
    else
      nxt_overrun = overrun;
  end

  // State, banks and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      slot     <= 3'd0;
      cyc      <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_ch    <= '0;
      pl_a     <= '0;
      pl_b     <= '0;
      pl_ch    <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      out_a    <= IDLE_WORD;
      out_b    <= IDLE_WORD;
      out_clk  <= 1'b0;
      out_slot <= 3'd0;
      out_sync <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt_state;
      slot     <= nxt_slot;
      cyc      <= nxt_cyc;
      pending  <= nxt_pending;
      overrun  <= nxt_overrun;
      if (in_valid) begin
        sh_a  <= in_a;
        sh_b  <= in_b;
        sh_ch <= in_ch;
      end
      if (load) begin
        pl_a  <= sh_a;
        pl_b  <= sh_b;
        pl_ch <= sh_ch;
      end
      out_a    <= nxt_out_a;
      out_b    <= nxt_out_b;
      out_clk  <= nxt_out_clk;
      out_slot <= nxt_slot;
      out_sync <= nxt_out_sync;
      busy     <= nxt_busy;
    end
  end

endmodule

// File: tb/tb_afe_tdm_mux.sv
// Directed bench for afe_tdm_mux: framing, back-to-back play, overrun, reset abort,
// and (with AFE_TDM_TESTPAT_EN) the test-pattern words.
module tb_afe_tdm_mux;

  localparam int unsigned N_MOD = 8;
  localparam int unsigned DW    = 10;

  logic                CLK = 1'b0;
  logic                RST;
  logic                in_valid;
  logic [5:0]          in_ch;
  logic [N_MOD*DW-1:0] in_a, in_b;
  logic                ovr_clr;
  logic [DW-1:0]       out_a, out_b;
  logic                out_clk, out_sync, busy, overrun;
  logic [2:0]          out_slot;
`ifdef AFE_TDM_TESTPAT_EN
  logic                tp_en;
`endif

  int n_cmp = 0;
  int n_err = 0;

  afe_tdm_mux dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef AFE_TDM_TESTPAT_EN
    .tp_en    (tp_en),
`endif
    .ovr_clr  (ovr_clr),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_clk  (out_clk),
    .out_slot (out_slot),
    .out_sync (out_sync),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_frame(input int ba, input int bb, input logic [5:0] ch);
    for (int k = 0; k < int'(N_MOD); k++) begin
      in_a[k*DW +: DW] = 10'(ba + k);
      in_b[k*DW +: DW] = 10'(bb + k);
    end
    in_ch = ch;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".a"},    32'(out_a), 32'd512);
    check({tag, ".b"},    32'(out_b), 32'd512);
    check({tag, ".clk"},  32'(out_clk), 32'd0);
    check({tag, ".slot"}, 32'(out_slot), 32'd0);
    check({tag, ".sync"}, 32'(out_sync), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Pulse a frame from idle; returns at the first cycle of slot 0
  task automatic start_frame(input int ba, input int bb, input logic [5:0] ch);
    set_frame(ba, bb, ch);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // Check ncyc cycles of a playing frame, optionally injecting up to two new frames
  task automatic play_check(input int ba, input int bb, input logic esync, input int ncyc,
                            input int p1, input int p1a, input int p1b, input logic [5:0] p1c,
                            input int p2, input int p2a, input int p2b, input logic [5:0] p2c);
    int s, c;
    for (int i = 0; i < ncyc; i++) begin
      s = i / 10;
      c = i % 10;
      check($sformatf("a[%0d]", i),    32'(out_a), 32'(ba + s));
      check($sformatf("b[%0d]", i),    32'(out_b), 32'(bb + s));
      check($sformatf("clk[%0d]", i),  32'(out_clk), 32'(c < 5));
      check($sformatf("slot[%0d]", i), 32'(out_slot), 32'(s));
      check($sformatf("sync[%0d]", i), 32'(out_sync), 32'(esync && s == 0));
      check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      in_valid = 1'b0;
      if (i == p1) begin set_frame(p1a, p1b, p1c); in_valid = 1'b1; end
      if (i == p2) begin set_frame(p2a, p2b, p2c); in_valid = 1'b1; end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; ovr_clr = 1'b0;
    in_a = '0; in_b = '0; in_ch = '0;
`ifdef AFE_TDM_TESTPAT_EN
    tp_en = 1'b0;
`endif
    tick(); tick();
    check_idle("rst");
    check("rst.ovr", 32'(overrun), 32'd0);
    RST = 1'b0;
    tick();

    // Single frame, ch matches SYNC_CH
    start_frame(1, 100, 6'd2);
    play_check(1, 100, 1'b1, 80, -1, 0, 0, 6'd0, -1, 0, 0, 6'd0);
    check_idle("post1");

    // Back-to-back frames, new frame arrives one cycle before frame end
    start_frame(10, 200, 6'd3);
    play_check(10, 200, 1'b0, 80, 78, 20, 300, 6'd2, -1, 0, 0, 6'd0);
    play_check(20, 300, 1'b1, 80, 78, 30, 400, 6'd7, -1, 0, 0, 6'd0);
    play_check(30, 400, 1'b0, 80, -1, 0, 0, 6'd0, -1, 0, 0, 6'd0);
    check_idle("post2");
    check("b2b.ovr", 32'(overrun), 32'd0);

    // Two frames during one play: newest wins, overrun sticks until cleared
    start_frame(60, 160, 6'd2);
    play_check(60, 160, 1'b1, 80, 20, 40, 140, 6'd5, 50, 50, 150, 6'd6);
    check("ovr.set", 32'(overrun), 32'd1);
    play_check(50, 150, 1'b0, 80, -1, 0, 0, 6'd0, -1, 0, 0, 6'd0);
    check_idle("post3");
    check("ovr.hold", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr.clr", 32'(overrun), 32'd0);

    // Frame on the final cycle with nothing pending: one idle cycle, then play
    start_frame(70, 170, 6'd1);
    play_check(70, 170, 1'b0, 80, 79, 80, 180, 6'd2, -1, 0, 0, 6'd0);
    check_idle("gap");
    tick();
    play_check(80, 180, 1'b1, 80, -1, 0, 0, 6'd0, -1, 0, 0, 6'd0);
    check_idle("post4");
    check("gap.ovr", 32'(overrun), 32'd0);

    // Reset in slot 3 with a pending frame discards everything
    start_frame(1, 100, 6'd2);
    play_check(1, 100, 1'b1, 35, 5, 90, 190, 6'd2, -1, 0, 0, 6'd0);
    RST = 1'b1;
    tick();
    check_idle("rst2");
    check("rst2.ovr", 32'(overrun), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("rst2.idle%0d", i));
    end

`ifdef AFE_TDM_TESTPAT_EN
    tp_en = 1'b1;
    start_frame(1, 100, 6'd9);
    for (int i = 0; i < 50; i++) tick();
    check("tp.slot", 32'(out_slot), 32'd5);
    check("tp.a",    32'(out_a), 32'h149);
    check("tp.b",    32'(out_b), 32'h349);
    check("tp.busy", 32'(busy), 32'd1);
    tp_en = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    check_idle("tp.end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/afe_tdm_mux.md
# afe_tdm_mux

Time-division multiplexer between the eight per-headstage SPI masters and the 10-bit parallel output bus to the acquisition PC. Once per SPI frame it captures all eight A/B sample pairs plus the channel index into a shadow bank. It then serialises them over eight slots, each with its own output strobe, asserting a sync flag on the selected channel. Double buffering lets a new frame arrive while the previous one is still being played out.

## Interface
- N_MOD, 8, number of SPI master modules (slots per frame)
- DW, 10, sample width
- SLOT_HALF, 5, CLK cycles per half slot (slot = 2*SLOT_HALF cycles)
- SYNC_CH, 6'd2, channel index that flags out_sync
- IDLE_WORD, 10'd512, out_a/out_b value when idle
- CLK  in  1  clock (the div_clk domain)
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle pulse: in_a/in_b/in_ch valid
- in_ch  in  6  channel index of this frame
- in_a  in  N_MOD*DW  module k sample A at [k*DW +: DW]
- in_b  in  N_MOD*DW  module k sample B, same packing
- ovr_clr  in  1  clears overrun
- out_a  out  DW  current slot sample A
- out_b  out  DW  current slot sample B
- out_clk  out  1  slot strobe, high in first half of each slot
- out_slot  out  3  current slot index
- out_sync  out  1  high for all of slot 0 when frame ch == SYNC_CH
- busy  out  1  sequencer playing a frame
- overrun  out  1  sticky: a pending frame was overwritten

## Operation
- Shadow bank {a, b, ch} plus a pending flag. On in_valid, load the shadow bank and set pending; the shadow bank is overwritten unconditionally.
- If in_valid arrives while pending=1 and the shadow has not transferred in the same cycle, set overrun. The newest frame wins.
- Play bank: loaded from the shadow when the sequencer is in IDLE, or on the last cycle of the last slot, with pending=1. The load clears pending, unless in_valid is also high in that cycle, in which case pending stays set with the new data.
- States:
  - IDLE: busy=0, out_clk=0, out_slot=0, out_sync=0, out_a=out_b=IDLE_WORD.
  - PLAY: slot counter 0..N_MOD-1 and cycle counter 0..2*SLOT_HALF-1. out_a/out_b = play bank[slot], held for the whole slot. out_clk=1 while the cycle counter < SLOT_HALF.
  - Transitions: IDLE→PLAY on load. End of slot N_MOD-1: to PLAY (back-to-back, slot 0, no gap) if pending, else to IDLE.
- ovr_clr clears overrun. If an overrun event occurs in the same cycle, the set wins.
- RST mid-frame: on the next edge all state and outputs return to reset values, and pending and the shadow are discarded.

## Timing
- Reset values: out_a=out_b=IDLE_WORD, out_clk=0, out_slot=0, out_sync=0, busy=0, overrun=0.
- All outputs are registered.
- Idle latency: in_valid in cycle 0 → shadow visible cycle 1 → play load at end of cycle 1 → slot 0 data with out_clk=1 visible in cycle 2.
- Frame length is N_MOD*2*SLOT_HALF = 80 cycles at defaults, which matches one SPI frame.
- in_valid in the final cycle of slot N_MOD-1 with pending=0: the sequencer goes to IDLE for exactly one cycle, then loads.
- Data changes only at slot boundaries, coincident with a rising out_clk. Consumers sample on the falling edge of out_clk.

## Configuration
- AFE_TDM_TESTPAT_EN defined:
  - Adds input port tp_en (1 bit).
  - When tp_en=1 in PLAY: out_a={1'b0, slot[2:0], ch[5:0]} and out_b={1'b1, slot[2:0], ch[5:0]}.
  - Requires DW=10 and N_MOD=8.
  - Framing, out_sync and overrun are unchanged.
- Not defined: no tp_en port, and sample data always passes through.

## Test plan
- Reset then a single in_valid with module k A=k+1, B=100+k, ch=2 → from cycle 2, 8 slots of 10 cycles with out_a=1..8, out_b=100..107, out_sync high only during slot 0, then IDLE with out_a=512.
- in_valid every 80 cycles aligned to the last slot cycle−1 → continuous PLAY, no idle gap, busy stays 1, overrun=0.
- Two in_valid pulses during one frame (ch=5, then ch=6) → second frame's data played next, overrun=1. ovr_clr → overrun=0.
- in_valid on the final cycle of slot 7 → exactly one IDLE cycle, then the new frame slot 0.
- RST asserted in slot 3 with a pending frame → next cycle all outputs at reset values. The pending frame is never played.
- With AFE_TDM_TESTPAT_EN, tp_en=1, ch=9 → slot 5 shows out_a=10'h149 and out_b=10'h349.
